hls_ap_ctrl_stream_bridge: RTL

- Adapts a valid/ready operand stream (a, b) onto an HLS ap_ctrl_hs block-level interface: drives ap_start and the operands, waits for ap_done/c_ap_vld, then presents the result on a valid/ready output stream.
- Sits between the Wishbone register/FIFO front-end and the divider HLS core, so software or DMA can stream operand pairs instead of polling start/done.
- Adds divide-by-zero bypass, a completion timeout, and status counters.

---
 rtl/hls_bridge_pkg.sv | 18 +
 rtl/hls_ap_ctrl_stream_bridge.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hls_bridge_pkg.sv
// Shared types and constants for the HLS ap_ctrl_hs stream bridge.
// Contents:
//   state_t     - bridge FSM states
//   DIV0_RESULT - result pattern returned for a bypassed divide-by-zero
//                 (truncated to the result width at the point of use)
package hls_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int unsigned DIV0_MAX_WIDTH = 64;
  localparam logic [DIV0_MAX_WIDTH-1:0] DIV0_RESULT = '1;

endpackage

// File: rtl/hls_ap_ctrl_stream_bridge.sv
// Valid/ready operand stream to HLS ap_ctrl_hs adapter.
// Accepts an (a, b) pair, starts the core, waits for ap_done / ap_c_vld and
// presents the result (plus an error flag) on a valid/ready output stream.
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   s_a, s_b, s_valid,
//   s_ready             - operand stream in
//   m_c, m_error,
//   m_valid, m_ready    - result stream out (m_error: div0 or timeout)
//   ap_start, ap_done,
//   ap_idle, ap_ready,
//   ap_a, ap_b, ap_c,
//   ap_c_vld            - HLS block-level handshake and operand/result ports
//   busy                - bridge is not idle
//   op_count            - results handed downstream (wraps)
//   err_count           - error results handed downstream (saturates)
module hls_ap_ctrl_stream_bridge
  import hls_bridge_pkg::*;
#(
  parameter int unsigned A_WIDTH       = 32,
  parameter int unsigned B_WIDTH       = 32,
  parameter int unsigned C_WIDTH       = 32,
  parameter int unsigned TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = '1,
  parameter bit          ZERO_BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [A_WIDTH-1:0]   s_a,
  input  logic [B_WIDTH-1:0]   s_b,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [C_WIDTH-1:0]   m_c,
  output logic                 m_error,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 ap_start,
  input  logic                 ap_done,
  input  logic                 ap_idle,
  input  logic                 ap_ready,
  output logic [A_WIDTH-1:0]   ap_a,
  output logic [B_WIDTH-1:0]   ap_b,
  input  logic [C_WIDTH-1:0]   ap_c,
  input  logic                 ap_c_vld,
  output logic                 busy,
  output logic [31:0]          op_count,
  output logic [15:0]          err_count
);

  localparam int unsigned OP_COUNT_WIDTH  = 32;
  localparam int unsigned ERR_COUNT_WIDTH = 16;

  state_t                     state_q, state_d;
  logic [A_WIDTH-1:0]         ap_a_d;
  logic [B_WIDTH-1:0]         ap_b_d;
  logic [C_WIDTH-1:0]         m_c_d;
  logic                       m_error_d;
  logic                       c_seen_q, c_seen_d;
  logic [TIMEOUT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]                op_count_d;
  logic [15:0]                err_count_d;
  logic                       done_hit;
  logic                       timed_out;

  // ap_idle is informational only; it never steers the FSM.
  logic unused_ap_idle;
  assign unused_ap_idle = ap_idle;

  // Abort after TIMEOUT_CYCLES cycles spent in WAIT; zero disables.
  assign timed_out = (TIMEOUT_CYCLES != '0) &&
                     (wait_cnt_q >= (TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1)));

  // Next-state and next-value logic for every register.
  always_comb begin
    state_d     = state_q;
    ap_a_d      = ap_a;
    ap_b_d      = ap_b;
    m_c_d       = m_c;
    m_error_d   = m_error;
    c_seen_d    = c_seen_q;
    wait_cnt_d  = wait_cnt_q;
    op_count_d  = op_count;
    err_count_d = err_count;
    done_hit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          ap_a_d = s_a;
          ap_b_d = s_b;
          if (ZERO_BYPASS && (s_b == '0)) begin
            m_c_d     = C_WIDTH'(DIV0_RESULT);
            m_error_d = 1'b1;
            state_d   = OUT;
          end else begin
            c_seen_d   = 1'b0;
            wait_cnt_d = '0;
            state_d    = START;
          end
        end
      end

      START: begin
        if (ap_c_vld) begin
          m_c_d    = ap_c;
          c_seen_d = 1'b1;
        end
        // A done is only meaningful once the core has taken the start.
        if (ap_ready) begin
          if (ap_done) begin
            done_hit = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (ap_c_vld) begin
          m_c_d    = ap_c;
          c_seen_d = 1'b1;
        end
        if (ap_done) begin
          done_hit = 1'b1;
        end else if (timed_out) begin
          m_c_d     = '0;
          m_error_d = 1'b1;
          state_d   = OUT;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + TIMEOUT_WIDTH'(1);
        end
      end

      OUT: begin
        if (m_ready) begin
          state_d    = IDLE;
          op_count_d = op_count + OP_COUNT_WIDTH'(1);
          if (m_error && (err_count != '1)) begin
            err_count_d = err_count + ERR_COUNT_WIDTH'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Completion: a result on the done cycle wins; a done with no result
    // ever seen since START is reported as an error.
    if (done_hit) begin
      state_d = OUT;
      if (ap_c_vld) begin
        m_c_d     = ap_c;
        m_error_d = 1'b0;
      end else if (c_seen_q) begin
        m_error_d = 1'b0;
      end else begin
        m_c_d     = '0;
        m_error_d = 1'b1;
      end
    end
  end

  // State and registered outputs; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s_ready    <= 1'b1;
      m_valid    <= 1'b0;
      m_c        <= '0;
      m_error    <= 1'b0;
      ap_start   <= 1'b0;
      ap_a       <= '0;
      ap_b       <= '0;
      busy       <= 1'b0;
      op_count   <= '0;
      err_count  <= '0;
      c_seen_q   <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      s_ready    <= (state_d == IDLE);
      m_valid    <= (state_d == OUT);
      ap_start   <= (state_d == START);
      busy       <= (state_d != IDLE);
      m_c        <= m_c_d;
      m_error    <= m_error_d;
      ap_a       <= ap_a_d;
      ap_b       <= ap_b_d;
      op_count   <= op_count_d;
      err_count  <= err_count_d;
      c_seen_q   <= c_seen_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
